word_byte_serializer: RTL
=========================

Name: word_byte_serializer

Overview:
Transmit-side counterpart to the byte-shift-in load mode of the 32-bit register (Q <= {Q[23:0], I[7:0]}). It accepts a word and emits it one byte per handshake, most-significant selected byte first. A receiving register that shifts in each byte reconstructs the word exactly. It sits between the datapath registers and any byte-wide link or memory port.

Parameters:
BYTES, 4, number of bytes in the input word (word width = 8*BYTES); legal values are 2 to 8.

Ports:
Clock  input  1  single clock, rising edge.
Reset  input  1  asynchronous reset, active-low; all state is cleared while Reset is low.
I  input  8*BYTES  word to transmit; sampled only on word accept.
Size  input  2  byte count, sampled on word accept: 00 = 1 byte (I[7:0]); 01 = 2 bytes (I[15:0]); 10 and 11 = all BYTES bytes.
WordValid  input  1  a word is offered on I/Size.
WordReady  output  1  serializer can accept a word.
ByteOut  output  8  current byte.
ByteValid  output  1  ByteOut is valid.
ByteReady  input  1  downstream accepts ByteOut.
Done  output  1  one-cycle pulse after the last byte of a word is accepted.

Behaviour:
- Reset (async assert, sync deassert to logic) gives:
  - state IDLE, WordReady = 1, ByteValid = 0, ByteOut = 8'h00, Done = 0.
  - internal shift register and byte counter cleared.
- States:
  - IDLE: WordReady = 1, ByteValid = 0.
  - SEND: WordReady = 0, ByteValid = 1.
- Word accept = WordValid & WordReady at a rising edge.
  - Latch I into the shift register and the byte count N from Size (1, 2 or BYTES).
  - Go to SEND. The first byte is visible with ByteValid = 1 on the next cycle, so latency from accept to first byte is 1 clock.
- Byte order is MSB-first within the selected bytes:
  - N = 2 sends I[15:8] then I[7:0].
  - N = BYTES sends I[8*BYTES-1 : 8*BYTES-8] first and I[7:0] last.
  - Selected bytes are left-aligned into the shift register on accept. Unselected upper bytes of I are ignored.
- Byte handshake = ByteValid & ByteReady at a rising edge.
  - Shift left by 8 and decrement the remaining count.
  - While ByteValid = 1 and ByteReady = 0, ByteOut holds stable. No byte is dropped or repeated.
- Last byte:
  - Its handshake returns the block to IDLE and registers Done = 1 for exactly the following cycle.
  - In that same cycle WordReady = 1, so a new word may be accepted while Done is high. Back-to-back words therefore have a 1-cycle gap on ByteValid.
- WordValid in SEND is ignored; the word is not consumed.
- ByteReady in IDLE is ignored.
- ByteOut in IDLE holds the last value shifted in; it is don't-care for checking except after reset.
- Reset low mid-word aborts immediately. The remaining bytes are discarded, Done does not pulse, and outputs return to reset values.
- Counter width is clog2(BYTES)+1. No wrap-around is possible because the count is reloaded only on accept.
- Throughput: 1 byte per clock when ByteReady is held high.

Decomposition:
- Shared package holds:
  - size codes SIZE_B1 = 2'b00, SIZE_B2 = 2'b01, SIZE_ALL = 2'b10.
  - the state encoding ST_IDLE, ST_SEND.
- Natural sub-module: byte_shift_out. It contains the 8*BYTES-bit shift register with load/shift enables and left-alignment by N, and exposes the top byte as ByteOut.
- The FSM, counter and Done stay in the top module.

Test Plan:
1. Full word, sink always ready: I = 32'hDEADBEEF, Size = 10, ByteReady = 1.
   -> ByteOut is DE, AD, BE, EF on 4 consecutive cycles starting 1 cycle after accept.
   -> Done pulses once the cycle after EF is accepted.
   -> A reference byte-shift-in register fed with these bytes reads 32'hDEADBEEF.
2. Partial sizes:
   - I = 32'h12345678, Size = 01 -> bytes 56, 78, then Done.
   - Size = 00 -> byte 78 only, then Done. Upper bytes never appear.
3. Backpressure: I = 32'hA1B2C3D4, ByteReady low for 3 cycles on byte 2.
   -> ByteOut holds B2 with ByteValid = 1 throughout the stall.
   -> Sequence remains A1, B2, C3, D4 with no repeat.
4. Back-to-back words: WordValid held high with 32'h01020304 then 32'h05060708.
   -> Second accept occurs in the Done cycle of the first word.
   -> Output is 01 02 03 04, one idle cycle, 05 06 07 08.
   -> WordValid asserted during SEND does not change the output.
5. Reset mid-word: assert Reset low after 2 bytes of 32'hCAFEF00D.
   -> Outputs go immediately to reset values (ByteValid = 0, WordReady = 1, ByteOut = 00).
   -> No Done pulse.
   -> A new word 32'h11223344 after release sends 11 22 33 44 correctly.

Source files
------------

// File: rtl/word_byte_serializer_pkg.sv
// Shared definitions for the word-to-byte serializer: size codes, FSM states,
// and the mapping from a size code to a byte count.
package word_byte_serializer_pkg;

   localparam logic [1:0] SIZE_B1  = 2'b00;
   localparam logic [1:0] SIZE_B2  = 2'b01;
   localparam logic [1:0] SIZE_ALL = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Codes 10 and 11 both mean "every byte of the word".
   function automatic int unsigned size_to_count(input logic [1:0] size,
                                                 input int unsigned bytes);
      case (size)
         SIZE_B1: return 1;
         SIZE_B2: return 2;
         default: return bytes;
      endcase
   endfunction

endpackage

// File: rtl/word_byte_serializer_if.sv
// Word-in / byte-out handshake bundle. The master side is the serializer,
// the slave side is whoever offers words and sinks bytes.
interface word_byte_serializer_if #(
   parameter int BYTES = 4
) ();

   logic [8*BYTES-1:0] I;
   logic [1:0]         Size;
   logic               WordValid;
   logic               WordReady;
   logic [7:0]         ByteOut;
   logic               ByteValid;
   logic               ByteReady;
   logic               Done;

   modport master (
      input  I, Size, WordValid, ByteReady,
      output WordReady, ByteOut, ByteValid, Done
   );

   modport slave (
      output I, Size, WordValid, ByteReady,
      input  WordReady, ByteOut, ByteValid, Done
   );

endinterface

// File: rtl/word_byte_serializer_byte_shift_out.sv
// Byte-wide left shift register. On load the selected low bytes of the word
// are left-aligned so the first byte to send always sits in the top byte.
module byte_shift_out #(
   parameter int BYTES = 4,
   parameter int CW    = $clog2(BYTES) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift,
   input  logic [8*BYTES-1:0] word,
   input  logic [CW-1:0]      count,
   output logic [7:0]         top_byte
);

   localparam int W = 8 * BYTES;

   logic [W-1:0] sreg;
   logic [W-1:0] aligned;

   // Push the unselected upper bytes off the top so the MSB selected byte leads.
   always_comb begin
      aligned = word << (8 * (BYTES - int'(count)));
   end

   // Load on word accept, shift one byte per byte handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= aligned;
      end else if (shift) begin
         sreg <= {sreg[W-9:0], 8'h00};
      end
   end

   assign top_byte = sreg[W-1 -: 8];

endmodule

// File: rtl/word_byte_serializer.sv
// Accepts a word and sends its selected bytes MSB-first, one per handshake,
// so a byte-shift-in register on the far side rebuilds the word.
module word_byte_serializer
   import word_byte_serializer_pkg::*;
#(
   parameter int BYTES = 4
) (
   input logic                    Clock,
   input logic                    Reset,
   word_byte_serializer_if.master bus
);

   localparam int CW = $clog2(BYTES) + 1;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] remaining;
   logic [CW-1:0] load_count;
   logic          word_acc;
   logic          byte_acc;
   logic          last_byte;
   logic          done;

   assign load_count = CW'(size_to_count(bus.Size, BYTES));
   assign word_acc   = bus.WordValid & bus.WordReady;
   assign byte_acc   = bus.ByteValid & bus.ByteReady;
   assign last_byte  = (remaining == CW'(1));
   assign bus.Done   = done;

   // State register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and handshake outputs; words are only taken in IDLE.
   always_comb begin
      state_nx      = state;
      bus.WordReady = 1'b0;
      bus.ByteValid = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.WordReady = 1'b1;
            if (bus.WordValid) begin
               state_nx = ST_SEND;
            end
         end
         ST_SEND: begin
            bus.ByteValid = 1'b1;
            if (bus.ByteReady && last_byte) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Bytes still to send; reloaded on every accept so it never wraps.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         remaining <= '0;
      end else if (word_acc) begin
         remaining <= load_count;
      end else if (byte_acc) begin
         remaining <= remaining - CW'(1);
      end
   end

   // One-cycle completion pulse following the last byte handshake.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         done <= 1'b0;
      end else begin
         done <= byte_acc & last_byte;
      end
   end

   byte_shift_out #(
      .BYTES (BYTES),
      .CW    (CW)
   ) u_shift (
      .clk      (Clock),
      .rst_n    (Reset),
      .load     (word_acc),
      .shift    (byte_acc),
      .word     (bus.I),
      .count    (load_count),
      .top_byte (bus.ByteOut)
   );

endmodule
